// File: rtl/sh7034_mac_ctl.sv
// ============================================================================
// sh7034_mac_ctl : CPU-side initiator for the SH7034 MAC unit port  (rev 1.0)
// ============================================================================
`default_nettype none

module sh7034_mac_ctl #(
  parameter int MUL_GAP = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_OP,
  input  logic        CMD_S,
  input  logic [31:0] CMD_RM,
  input  logic [31:0] CMD_RN,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic [31:0] RM_NEXT,
  output logic [31:0] RN_NEXT,
  output logic [27:0] MEM_A,
  output logic        MEM_REQ,
  input  logic        MEM_BUSY,
  input  logic [31:0] MEM_DI,
  output logic [27:0] MAC_A,
  output logic [31:0] MAC_DI,
  input  logic [31:0] MAC_DO,
  output logic [1:0]  MAC_SEL,
  output logic [3:0]  MAC_OP,
  output logic        MAC_S,
  output logic        MAC_WE
);

  localparam int GAP_W = (MUL_GAP < 2) ? 1 : $clog2(MUL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MUL_GAP);

  localparam logic [2:0] OP_MULU  = 3'd0;
  localparam logic [2:0] OP_MULS  = 3'd1;
  localparam logic [2:0] OP_MACW  = 3'd2;
  localparam logic [2:0] OP_LDSL  = 3'd3;
  localparam logic [2:0] OP_LDSH  = 3'd4;
  localparam logic [2:0] OP_STSL  = 3'd5;
  localparam logic [2:0] OP_STSH  = 3'd6;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    STRB  = 4'd1,
    RD_N  = 4'd2,
    WB    = 4'd3,
    RD_M  = 4'd4,
    WA    = 4'd5,
    STS_W = 4'd6,
    STS_R = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       op;
  logic             s;
  logic [31:0]      rm, rn;
  logic [31:0]      mem_data;
  logic [31:0]      res_data;
  logic [GAP_W-1:0] gap;
  logic             load_gap;

  assign CMD_READY = (state == IDLE);
  assign RES_DATA  = res_data;
  assign RM_NEXT   = (op == OP_MACW) ? rm + 32'd2 : rm;
  assign RN_NEXT   = (op == OP_MACW) ? rn + 32'd2 : rn;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op       <= 3'd0;
      s        <= 1'b0;
      rm       <= 32'd0;
      rn       <= 32'd0;
      mem_data <= 32'd0;
      res_data <= 32'd0;
      gap      <= '0;
    end else begin
      state <= state_nx;
      if (CMD_VALID && CMD_READY) begin
        op       <= CMD_OP;
        s        <= CMD_S;
        rm       <= CMD_RM;
        rn       <= CMD_RN;
        res_data <= 32'd0;
      end
      if ((state == RD_N || state == RD_M) && !MEM_BUSY)
        mem_data <= MEM_DI;
      if (state == STS_R && CE_R)
        res_data <= MAC_DO;
      // The gap counter outlives the command so a later STS still honours it
      if (load_gap)
        gap <= GAP_LOAD;
      else if (CE_R && gap != '0)
        gap <= gap - GAP_W'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    MAC_WE    = 1'b0;
    MAC_SEL   = 2'b00;
    MAC_OP    = 4'b0000;
    MAC_A     = 28'd0;
    MAC_DI    = 32'd0;
    MAC_S     = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_A     = 28'd0;
    RES_VALID = 1'b0;
    load_gap  = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          case (CMD_OP)
            OP_MACW:          state_nx = RD_N;
            OP_STSL, OP_STSH: state_nx = STS_W;
            default:          state_nx = STRB;
          endcase
        end
      end
      STRB: begin
        MAC_WE = CE_R;
        case (op)
          OP_MULU: begin
            MAC_SEL = 2'b10; MAC_OP = 4'b0110; MAC_DI = {rm[15:0], rn[15:0]};
            load_gap = CE_R;
          end
          OP_MULS: begin
            MAC_SEL = 2'b10; MAC_OP = 4'b0111; MAC_DI = {rm[15:0], rn[15:0]};
            load_gap = CE_R;
          end
          OP_LDSL: begin MAC_SEL = 2'b01; MAC_OP = 4'b0100; MAC_DI = rm; end
          OP_LDSH: begin MAC_SEL = 2'b10; MAC_OP = 4'b0100; MAC_DI = rm; end
          default: begin MAC_SEL = 2'b11; MAC_OP = 4'b1111; end
        endcase
        if (CE_R) state_nx = DONE;
      end
      RD_N: begin
        MEM_REQ = 1'b1;
        MEM_A   = {rn[27:2], 2'b00};
        if (!MEM_BUSY) state_nx = WB;
      end
      // MB goes first so the accumulate fires on the MA strobe
      WB: begin
        MAC_WE = CE_R; MAC_SEL = 2'b10; MAC_OP = 4'b1011;
        MAC_A  = rn[27:0]; MAC_DI = mem_data; MAC_S = s;
        if (CE_R) state_nx = RD_M;
      end
      RD_M: begin
        MEM_REQ = 1'b1;
        MEM_A   = {rm[27:2], 2'b00};
        if (!MEM_BUSY) state_nx = WA;
      end
      WA: begin
        MAC_WE = CE_R; MAC_SEL = 2'b01; MAC_OP = 4'b1011;
        MAC_A  = rm[27:0]; MAC_DI = mem_data; MAC_S = s;
        load_gap = CE_R;
        if (CE_R) state_nx = DONE;
      end
      STS_W: begin
        if (gap == '0) state_nx = STS_R;
      end
      STS_R: begin
        MAC_SEL = (op == OP_STSH) ? 2'b10 : 2'b01;
        if (CE_R) state_nx = DONE;
      end
      DONE: begin
        RES_VALID = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sh7034_mac_ctl.sv
// ============================================================================
// tb_sh7034_mac_ctl : scoreboard bench with MAC unit and memory models (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sh7034_mac_ctl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE_R;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [2:0]  CMD_OP = 3'd0;
  logic        CMD_S = 1'b0;
  logic [31:0] CMD_RM = 32'd0;
  logic [31:0] CMD_RN = 32'd0;
  logic        RES_VALID;
  logic [31:0] RES_DATA, RM_NEXT, RN_NEXT;
  logic [27:0] MEM_A;
  logic        MEM_REQ, MEM_BUSY;
  logic [31:0] MEM_DI;
  logic [27:0] MAC_A;
  logic [31:0] MAC_DI, MAC_DO;
  logic [1:0]  MAC_SEL;
  logic [3:0]  MAC_OP;
  logic        MAC_S, MAC_WE;

  sh7034_mac_ctl #(.MUL_GAP(1)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_S(CMD_S),
    .CMD_RM(CMD_RM), .CMD_RN(CMD_RN),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RM_NEXT(RM_NEXT), .RN_NEXT(RN_NEXT),
    .MEM_A(MEM_A), .MEM_REQ(MEM_REQ), .MEM_BUSY(MEM_BUSY), .MEM_DI(MEM_DI),
    .MAC_A(MAC_A), .MAC_DI(MAC_DI), .MAC_DO(MAC_DO),
    .MAC_SEL(MAC_SEL), .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int cyc = 0, ce_div = 1, phase = 0;
  int mem_wait = 0, busy_cnt = 0, req_len = 0;
  int res_cnt = 0, strobe_cyc = 0, res_cyc = 0;
  logic [31:0] mem [0:255];

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  op;
    logic [27:0] a;
    logic [31:0] di;
    logic        s;
  } strobe_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] rm;
    logic [31:0] rn;
  } res_t;

  strobe_t     sq[$];
  res_t        rq[$];
  logic [27:0] aq[$];
  strobe_t     s_got, s_exp;
  res_t        r_got, r_exp;
  logic [27:0] a_exp;

  // Clock-enable divider and a memory that stays busy mem_wait cycles per read
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    phase <= (phase + 1 >= ce_div) ? 0 : phase + 1;
    if (MEM_REQ && MEM_BUSY) busy_cnt <= busy_cnt + 1;
    else                     busy_cnt <= 0;
  end
  assign CE_R     = (phase == 0);
  assign MEM_BUSY = MEM_REQ && (busy_cnt < mem_wait);
  assign MEM_DI   = mem[MEM_A[9:2]];

  // MAC unit model: products land on the first CE_R slot after their strobe
  logic [31:0] macl = 32'd0, pend_l = 32'd0;
  logic [9:0]  mach = 10'd0, pend_h = 10'd0;
  logic [15:0] mb = 16'd0;
  logic        pend = 1'b0;

  function automatic logic [31:0] smul(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic logic [41:0] mac_acc(logic [9:0] h, logic [31:0] l,
                                          logic [15:0] a, logic [15:0] b);
    logic [31:0] p;
    p = smul(a, b);
    return {h, l} + {{10{p[31]}}, p};
  endfunction

  always @(posedge CLK) begin
    if (MAC_WE && CE_R) begin
      case ({MAC_SEL, MAC_OP})
        6'b10_0110: begin
          pend <= 1'b1; pend_h <= mach;
          pend_l <= {16'h0, MAC_DI[31:16]} * {16'h0, MAC_DI[15:0]};
        end
        6'b10_0111: begin
          pend <= 1'b1; pend_h <= mach; pend_l <= smul(MAC_DI[31:16], MAC_DI[15:0]);
        end
        6'b01_0100: begin macl <= MAC_DI; pend <= 1'b0; end
        6'b10_0100: begin mach <= MAC_DI[9:0]; pend <= 1'b0; end
        6'b11_1111: begin macl <= 32'd0; mach <= 10'd0; pend <= 1'b0; end
        6'b10_1011: mb <= MAC_A[1] ? MAC_DI[15:0] : MAC_DI[31:16];
        6'b01_1011: begin
          pend <= 1'b1;
          {pend_h, pend_l} <= mac_acc(mach, macl, MAC_A[1] ? MAC_DI[15:0] : MAC_DI[31:16], mb);
        end
        default: ;
      endcase
    end else if (pend && CE_R) begin
      macl <= pend_l;
      mach <= pend_h;
      pend <= 1'b0;
    end
  end
  assign MAC_DO = (MAC_SEL == 2'b01) ? macl :
                  (MAC_SEL == 2'b10) ? {{22{mach[9]}}, mach} : 32'd0;

  // Scoreboard monitors
  always @(negedge CLK) begin
    if (MAC_WE) begin
      checks++;
      s_got = {MAC_SEL, MAC_OP, MAC_A, MAC_DI, MAC_S};
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got sel=%b op=%b a=%h di=%h s=%b required no strobe",
                 MAC_SEL, MAC_OP, MAC_A, MAC_DI, MAC_S);
      end else begin
        s_exp = sq.pop_front();
        if (!CE_R || s_got !== s_exp) begin
          errors++;
          $display("FAIL strobe got ce=%b sel=%b op=%b a=%h di=%h s=%b required ce=1 sel=%b op=%b a=%h di=%h s=%b",
                   CE_R, s_got.sel, s_got.op, s_got.a, s_got.di, s_got.s,
                   s_exp.sel, s_exp.op, s_exp.a, s_exp.di, s_exp.s);
        end
      end
      strobe_cyc = cyc;
    end
    if (RES_VALID) begin
      checks++;
      r_got = {RES_DATA, RM_NEXT, RN_NEXT};
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got data=%h required no result", RES_DATA);
      end else begin
        r_exp = rq.pop_front();
        if (r_got !== r_exp) begin
          errors++;
          $display("FAIL result got data=%h rm=%h rn=%h required data=%h rm=%h rn=%h",
                   r_got.data, r_got.rm, r_got.rn, r_exp.data, r_exp.rm, r_exp.rn);
        end
      end
      res_cyc = cyc;
      res_cnt++;
    end
    if (!MEM_REQ) begin
      req_len = 0;
    end else begin
      if (req_len == 0) begin
        checks++;
        if (aq.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got addr=%h required no read", MEM_A);
        end else begin
          a_exp = aq.pop_front();
          if (MEM_A !== a_exp) begin
            errors++;
            $display("FAIL read_addr got %h required %h", MEM_A, a_exp);
          end
        end
      end
      req_len++;
      if (!MEM_BUSY) begin
        checks++;
        if (req_len != mem_wait + 1) begin
          errors++;
          $display("FAIL req_len got %0d required %0d", req_len, mem_wait + 1);
        end
        req_len = 0;
      end
    end
  end

  task automatic push_strobe(logic [1:0] sel, logic [3:0] op, logic [27:0] a,
                             logic [31:0] di, logic s);
    sq.push_back({sel, op, a, di, s});
  endtask

  // Reference model of the controller's unit-side and memory-side traffic
  task automatic expect_cmd(logic [2:0] op, logic s, logic [31:0] rm, logic [31:0] rn,
                            logic [31:0] data);
    case (op)
      3'd0: push_strobe(2'b10, 4'b0110, 28'd0, {rm[15:0], rn[15:0]}, 1'b0);
      3'd1: push_strobe(2'b10, 4'b0111, 28'd0, {rm[15:0], rn[15:0]}, 1'b0);
      3'd2: begin
        aq.push_back({rn[27:2], 2'b00});
        aq.push_back({rm[27:2], 2'b00});
        push_strobe(2'b10, 4'b1011, rn[27:0], mem[rn[9:2]], s);
        push_strobe(2'b01, 4'b1011, rm[27:0], mem[rm[9:2]], s);
      end
      3'd3: push_strobe(2'b01, 4'b0100, 28'd0, rm, 1'b0);
      3'd4: push_strobe(2'b10, 4'b0100, 28'd0, rm, 1'b0);
      3'd7: push_strobe(2'b11, 4'b1111, 28'd0, 32'd0, 1'b0);
      default: ;
    endcase
    rq.push_back({data, (op == 3'd2) ? rm + 32'd2 : rm, (op == 3'd2) ? rn + 32'd2 : rn});
  endtask

  task automatic drive_cmd(logic [2:0] op, logic s, logic [31:0] rm, logic [31:0] rn);
    int n;
    @(negedge CLK);
    CMD_OP = op; CMD_S = s; CMD_RM = rm; CMD_RN = rn; CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 300) begin @(negedge CLK); n++; end
    if (!CMD_READY) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout got 0 required 1 within 300 cycles");
    end
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic wait_results(int target);
    int n;
    n = 0;
    while (res_cnt < target && n < 400) begin @(negedge CLK); n++; end
    if (res_cnt < target) begin
      checks++; errors++;
      $display("FAIL res_timeout got %0d results required %0d", res_cnt, target);
    end
  endtask

  task automatic run(logic [2:0] op, logic s, logic [31:0] rm, logic [31:0] rn,
                     logic [31:0] data);
    int t;
    expect_cmd(op, s, rm, rn, data);
    t = res_cnt + 1;
    drive_cmd(op, s, rm, rn);
    wait_results(t);
  endtask

  task automatic test_reset();
    logic [103:0] got;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    got = {CMD_READY, RES_VALID, RES_DATA, MEM_REQ, MAC_WE, MAC_SEL, MAC_OP, MAC_S, MAC_A, MAC_DI};
    checks++;
    if (got !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 28'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_outputs got %h required %h", got,
               {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 28'd0, 32'd0});
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_muls();
    ce_div = 1;
    run(3'd1, 1'b0, 32'h0000FFFE, 32'h00000003, 32'd0);
    checks++;
    if (res_cyc - strobe_cyc != 1) begin
      errors++;
      $display("FAIL mul_latency got %0d required 1", res_cyc - strobe_cyc);
    end
    run(3'd5, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFA);
  endtask

  task automatic test_mac_w(int wait_cycles);
    ce_div = 1;
    mem_wait = wait_cycles;
    mem[64]  = 32'h0005ABCD;
    mem[128] = 32'h12340007;
    run(3'd7, 1'b0, 32'd0, 32'd0, 32'd0);
    run(3'd2, 1'b0, 32'h00000202, 32'h00000100, 32'd0);
    run(3'd5, 1'b0, 32'd0, 32'd0, 32'h00000023);
    run(3'd6, 1'b0, 32'd0, 32'd0, 32'h00000000);
    mem_wait = 0;
  endtask

  task automatic test_ce_slow();
    ce_div = 4;
    run(3'd4, 1'b0, 32'h000003FF, 32'd0, 32'd0);
    run(3'd6, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF);
  endtask

  task automatic test_back_to_back();
    int t;
    ce_div = 4;
    run(3'd3, 1'b0, 32'h12345678, 32'd0, 32'd0);
    expect_cmd(3'd0, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'd0);
    expect_cmd(3'd5, 1'b0, 32'd0, 32'd0, 32'hFFFE0001);
    t = res_cnt + 2;
    drive_cmd(3'd0, 1'b0, 32'h0000FFFF, 32'h0000FFFF);
    drive_cmd(3'd5, 1'b0, 32'd0, 32'd0);
    wait_results(t);
  endtask

  task automatic test_wrap();
    ce_div = 1;
    mem_wait = 1;
    mem[255] = 32'h00020003;
    mem[65]  = 32'h00040005;
    run(3'd2, 1'b1, 32'h00000105, 32'hFFFFFFFE, 32'd0);
    mem_wait = 0;
  endtask

  task automatic test_reset_mid();
    logic [103:0] got;
    int n;
    ce_div = 1;
    mem_wait = 8;
    mem[64] = 32'h0005ABCD;
    aq.push_back(28'h0000100);
    aq.push_back(28'h0000200);
    push_strobe(2'b10, 4'b1011, 28'h0000100, 32'h0005ABCD, 1'b0);
    drive_cmd(3'd2, 1'b0, 32'h00000202, 32'h00000100);
    n = 0;
    while (!(MEM_REQ && MEM_A == 28'h0000200) && n < 200) begin @(negedge CLK); n++; end
    checks++;
    if (!(MEM_REQ && MEM_A == 28'h0000200)) begin
      errors++;
      $display("FAIL rd_m_reach got req=%b addr=%h required req=1 addr=0000200", MEM_REQ, MEM_A);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    got = {CMD_READY, RES_VALID, RES_DATA, MEM_REQ, MAC_WE, MAC_SEL, MAC_OP, MAC_S, MAC_A, MAC_DI};
    checks++;
    if (got !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 28'd0, 32'd0}) begin
      errors++;
      $display("FAIL midreset_outputs got %h required %h", got,
               {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 28'd0, 32'd0});
    end
    RST = 1'b0;
    mem_wait = 0;
    repeat (20) @(negedge CLK);
    checks++;
    if (sq.size() != 0 || aq.size() != 0 || rq.size() != 0 || CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet got sq=%0d aq=%0d rq=%0d ready=%b required 0 0 0 1",
               sq.size(), aq.size(), rq.size(), CMD_READY);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    test_reset();
    test_muls();
    test_mac_w(0);
    test_mac_w(5);
    test_ce_slow();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got no finish required finish before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sh7034_mac_ctl.md
Name: sh7034_mac_ctl

Overview:
- CPU-side initiator for the SH7034 multiply/accumulate unit port: MAC_SEL, MAC_OP, MAC_S and MAC_WE, plus the CBUS data and address lines into the unit.
- Takes one decoded MAC-class instruction at a time from the execute stage.
- Fetches MAC.W memory operands over a word-read bus, drives the unit write strobes on CE_R slots and returns STS read data.
- Returns post-incremented register pointers to the register file.

Parameters:
- MUL_GAP, 1: CE_R slots that must elapse after a MULx.W or MAC.W operand-A strobe before an STS read may be sampled.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CE_R  in  1  rising-phase clock enable; all MAC_WE strobes and STS samples happen only in CE_R cycles.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller idle, command accepted when VALID&READY.
- CMD_OP  in  3  0 MULU.W, 1 MULS.W, 2 MAC.W, 3 LDS MACL, 4 LDS MACH, 5 STS MACL, 6 STS MACH, 7 CLRMAC.
- CMD_S  in  1  SR.S, forwarded as MAC_S for MAC.W.
- CMD_RM  in  32  Rm value.
- CMD_RN  in  32  Rn value.
- RES_VALID  out  1  one-CLK pulse, command complete.
- RES_DATA  out  32  STS result; 0 for other ops.
- RM_NEXT  out  32  Rm+2 for MAC.W, else CMD_RM.
- RN_NEXT  out  32  Rn+2 for MAC.W, else CMD_RN.
- MEM_A  out  28  word-read address.
- MEM_REQ  out  1  read request.
- MEM_BUSY  in  1  read not yet complete.
- MEM_DI  in  32  read data, longword-aligned lane.
- MAC_A  out  28  address presented to the unit's CBUS_A.
- MAC_DI  out  32  data presented to the unit's CBUS_DI.
- MAC_DO  in  32  unit's CBUS_DO.
- MAC_SEL  out  2  unit target select.
- MAC_OP  out  4  unit opcode.
- MAC_S  out  1  saturation flag.
- MAC_WE  out  1  unit write strobe.

Behaviour:
- Reset: state IDLE. CMD_READY=1. RES_VALID=0. RES_DATA=0. MEM_REQ=0. MAC_WE=0. MAC_SEL=0. MAC_OP=0. MAC_S=0. MAC_A=0. MAC_DI=0. Gap counter=0. Reset mid-command abandons it with no further strobe.
- Command capture: latch CMD_* on VALID&READY. CMD_READY=0 until the cycle after the RES_VALID pulse.
- Strobe rule: a "strobe" holds MAC_WE=1 with stable SEL/OP/A/DI for exactly the first CE_R cycle reached in that state. MAC_WE=0 in all other cycles.
- MULU.W / MULS.W: one strobe, SEL=10, OP=0110/0111, DI={Rm[15:0],Rn[15:0]}. Load gap counter=MUL_GAP. RES_VALID on the next CLK.
- LDS MACL / MACH: one strobe, SEL=01/10, OP=0100, DI=Rm. Then RES_VALID.
- CLRMAC: one strobe, SEL=11, OP=1111. Then RES_VALID.
- MAC.W sequence:
  - RD_N: MEM_A=Rn[27:0]&~3. MEM_REQ held until the first cycle with MEM_BUSY=0; capture MEM_DI there.
  - WB: strobe SEL=10, OP=1011, A=Rn[27:0], DI=captured data, S=CMD_S.
  - RD_M: same as RD_N using Rm.
  - WA: strobe SEL=01, OP=1011, A=Rm[27:0], S=CMD_S. Load gap counter=MUL_GAP.
  - DONE: RES_VALID.
  - MB is loaded before MA, so the accumulate executes on the MA strobe.
- STS MACL / MACH: wait in STS_W while gap counter>0; the counter decrements on CE_R. Then drive SEL=01/10, MAC_WE=0. Sample MAC_DO on the next CE_R cycle into RES_DATA. Pulse RES_VALID.
- Gap counter: persists across commands; it is not reset by new commands.
- Pointer arithmetic: 32-bit modulo. 0xFFFFFFFE+2 wraps to 0x00000000. Odd pointers are used as-is; the unit selects the lane via A[1].
- MEM_BUSY held high: the controller stalls indefinitely with MEM_REQ asserted. No timeout.
- CMD_OP decodes are exhaustive; no undefined encodings.

Test Plan:
- MULS.W Rm=0x0000FFFE (-2), Rn=0x00000003, CE_R every cycle -> one strobe SEL=10, OP=0111, DI=0xFFFE0003. RES_VALID 1 CLK later. A following STS MACL returns 0xFFFFFFFA.
- CLRMAC, then MAC.W Rn=0x100, Rm=0x202, memory[0x100]=0x0005xxxx, memory[0x200]=0xxxxx0007:
  - Reads at 0x100 then 0x200; WB then WA strobes.
  - RN_NEXT=0x102, RM_NEXT=0x204.
  - STS MACL=0x23, STS MACH=0.
- Same MAC.W with MEM_BUSY high for 5 cycles per read -> MEM_REQ held 6 cycles each. No strobe before data is captured. Result unchanged.
- CE_R every 4th cycle, LDS MACH Rm=0x3FF, then STS MACH -> strobe only on a CE_R cycle. RES_DATA=0xFFFFFFFF (sign-extended).
- STS MACL issued immediately after MULU.W 0xFFFF*0xFFFF -> STS waits MUL_GAP CE_R slots. Returns 0xFFFE0001, not the stale MACL value.
- RST asserted during RD_M of a MAC.W -> no WA strobe. Outputs return to reset values next CLK. CMD_READY=1.
